settle_checker: RTL and testbench

Synthesizable monitor that sits directly downstream of a single-source fan-out stage. The stage drives one source bit into WIDTH derived signals: buffers, inverters, continuous assigns and combinational processes. On every source transition, the monitor measures how many clock cycles the derived bus takes to reach its expected value. It then reports the latency, or flags a timeout together with the offending bits. Per-run event and error counts are kept for the bench or for on-chip readout.

---
 rtl/settle_pkg.sv | 14 +
 rtl/settle_checker_if.sv | 39 +++
 rtl/sat_counter.sv | 23 ++
 rtl/settle_checker.sv | 121 ++++++++++++
 tb/tb_settle_checker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/settle_pkg.sv
// Shared types and helpers for the fan-out settle monitor.
// Imported by the interface, the counter and the checker top.
package settle_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } settle_state_t;

  function automatic int lat_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/settle_checker_if.sv
// Bus between the fan-out stage / bench and the settle monitor.
// The master drives stimulus; the slave is the monitor.
interface settle_checker_if #(
  parameter int WIDTH    = 8,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
);
  import settle_pkg::*;

  localparam int LAT_W = lat_w(MAX_WAIT);

  logic             en;
  logic             clr;
  logic             src;
  logic [WIDTH-1:0] inv_mask;
  logic [WIDTH-1:0] obs;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [LAT_W-1:0] latency;
  logic [WIDTH-1:0] mismatch;
  logic [CNT_W-1:0] events;
  logic [CNT_W-1:0] errors;

  modport master (
    output en, clr, src, inv_mask, obs,
    input  busy, done, timeout,
    input  latency, mismatch,
    input  events, errors
  );

  modport slave (
    input  en, clr, src, inv_mask, obs,
    output busy, done, timeout,
    output latency, mismatch,
    output events, errors
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; never wraps past all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/settle_checker.sv
// Measures how long a fan-out bus takes to follow its source bit.
// Reports latency on settle, offending bits on timeout.
module settle_checker
  import settle_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  settle_checker_if.slave bus
);

  localparam int LAT_W = lat_w(MAX_WAIT);
  localparam logic [LAT_W-1:0] LAST =
    LAT_W'(MAX_WAIT - 1);

  settle_state_t    state;
  logic             src_q;
  logic [LAT_W-1:0] cnt;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;
  logic             busy_q;
  logic             done_q;
  logic             tmo_q;
  logic [LAT_W-1:0] lat_q;
  logic [WIDTH-1:0] mis_q;
  logic             chg;
  logic             ev_inc;
  logic             err_inc;
  logic [CNT_W-1:0] ev_q;
  logic [CNT_W-1:0] err_q;

  assign chg   = bus.en & (bus.src != src_q);
  assign exp_d = {WIDTH{bus.src}} ^ bus.inv_mask;

  // Every accepted transition counts, retriggers included.
  assign ev_inc  = chg;
  assign err_inc = (state == WAIT) && bus.en && !chg &&
                   (bus.obs != exp_q) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= 1'b0;
      cnt    <= '0;
      exp_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      lat_q  <= '0;
      mis_q  <= '0;
    end else begin
      src_q  <= bus.src;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chg) begin
            state  <= WAIT;
            cnt    <= '0;
            exp_q  <= exp_d;
            busy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (!bus.en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (chg) begin
            cnt   <= '0;
            exp_q <= exp_d;
          end else if (bus.obs == exp_q) begin
            done_q <= 1'b1;
            lat_q  <= cnt;
            mis_q  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == LAST) begin
            tmo_q  <= 1'b1;
            mis_q  <= bus.obs ^ exp_q;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_events (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (ev_inc),
    .q     (ev_q)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (err_inc),
    .q     (err_q)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = tmo_q;
  assign bus.latency  = lat_q;
  assign bus.mismatch = mis_q;
  assign bus.events   = ev_q;
  assign bus.errors   = err_q;

endmodule

// File: tb/tb_settle_checker.sv
// Directed bench for settle_checker and sat_counter.
// Drives after the rising edge, samples 1 time unit later.
module tb_settle_checker;

  localparam int WIDTH    = 8;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic       sc_clr;
  logic       sc_inc;
  logic [1:0] sc_q;

  settle_checker_if #(
    .WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) bus ();

  settle_checker #(
    .WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sat_counter #(.W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .q     (sc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.src = 1'b0;
    bus.inv_mask = '0;
    bus.obs = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_tmo", 32'(bus.timeout), 0);
    chk("rst_lat", 32'(bus.latency), 0);
    chk("rst_mis", 32'(bus.mismatch), 0);
    chk("rst_ev", 32'(bus.events), 0);
    chk("rst_err", 32'(bus.errors), 0);
    rst_n = 1'b1;
    bus.en = 1'b1;
    tick();

    // settles after 3 compare cycles
    bus.inv_mask = 8'h80;
    bus.obs = 8'h00;
    bus.src = 1'b1;
    tick();
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_ev", 32'(bus.events), 1);
    tick();
    tick();
    tick();
    chk("t1_nodone", 32'(bus.done), 0);
    chk("t1_busy2", 32'(bus.busy), 1);
    bus.obs = 8'h7F;
    tick();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_lat", 32'(bus.latency), 3);
    chk("t1_mis", 32'(bus.mismatch), 0);
    chk("t1_idle", 32'(bus.busy), 0);
    tick();
    chk("t1_pulse", 32'(bus.done), 0);

    // immediate settle
    bus.src = 1'b0;
    bus.obs = 8'h80;
    tick();
    chk("t2_busy", 32'(bus.busy), 1);
    tick();
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_lat", 32'(bus.latency), 0);
    chk("t2_ev", 32'(bus.events), 2);
    tick();

    // timeout
    bus.inv_mask = 8'h00;
    bus.obs = 8'h00;
    bus.src = 1'b1;
    tick();
    repeat (14) tick();
    chk("t3_notmo", 32'(bus.timeout), 0);
    chk("t3_busy", 32'(bus.busy), 1);
    tick();
    chk("t3_tmo", 32'(bus.timeout), 1);
    chk("t3_nodone", 32'(bus.done), 0);
    chk("t3_mis", 32'(bus.mismatch), 32'hFF);
    chk("t3_err", 32'(bus.errors), 1);
    chk("t3_lat", 32'(bus.latency), 0);
    tick();
    chk("t3_pulse", 32'(bus.timeout), 0);
    chk("t3_idle", 32'(bus.busy), 0);
    chk("t3_mishold", 32'(bus.mismatch), 32'hFF);

    // retrigger two cycles after the first change
    bus.inv_mask = 8'h0F;
    bus.obs = 8'hAA;
    bus.src = 1'b0;
    tick();
    chk("t4_ev1", 32'(bus.events), 4);
    tick();
    bus.src = 1'b1;
    tick();
    chk("t4_ev2", 32'(bus.events), 5);
    chk("t4_busy", 32'(bus.busy), 1);
    bus.obs = 8'h0F;
    tick();
    tick();
    chk("t4_stale", 32'(bus.done), 0);
    chk("t4_busy2", 32'(bus.busy), 1);
    bus.obs = 8'hF0;
    tick();
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_lat", 32'(bus.latency), 2);
    chk("t4_mis", 32'(bus.mismatch), 0);
    tick();
    chk("t4_once", 32'(bus.done), 0);

    // enable drop mid-WAIT
    bus.inv_mask = 8'h00;
    bus.obs = 8'hFF;
    bus.src = 1'b0;
    tick();
    chk("t5_ev", 32'(bus.events), 6);
    tick();
    bus.en = 1'b0;
    tick();
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_tmo", 32'(bus.timeout), 0);
    bus.src = 1'b1;
    tick();
    chk("t5_ign", 32'(bus.busy), 0);
    chk("t5_ev2", 32'(bus.events), 6);
    chk("t5_err", 32'(bus.errors), 1);
    bus.en = 1'b1;

    // clear alongside a timeout
    bus.src = 1'b0;
    tick();
    chk("t6_ev", 32'(bus.events), 7);
    repeat (14) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t6_tmo", 32'(bus.timeout), 1);
    chk("t6_err", 32'(bus.errors), 0);
    chk("t6_ev0", 32'(bus.events), 0);
    chk("t6_lat", 32'(bus.latency), 2);
    tick();

    // async reset mid-WAIT
    bus.obs = 8'h00;
    bus.src = 1'b1;
    tick();
    chk("t7_busy", 32'(bus.busy), 1);
    chk("t7_ev", 32'(bus.events), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rbusy", 32'(bus.busy), 0);
    chk("t7_rlat", 32'(bus.latency), 0);
    chk("t7_rmis", 32'(bus.mismatch), 0);
    chk("t7_rev", 32'(bus.events), 0);
    bus.src = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("t7_idle", 32'(bus.busy), 0);
    chk("t7_nopls", 32'(bus.done | bus.timeout), 0);
    tick();
    chk("t7_idle2", 32'(bus.busy), 0);

    // counter saturation
    sc_inc = 1'b1;
    repeat (5) tick();
    chk("sat_hold", 32'(sc_q), 3);
    sc_clr = 1'b1;
    tick();
    chk("sat_clr", 32'(sc_q), 0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
